// File: rtl/sponge_arbiter.sv
// sponge_arbiter: round-robin scheduler that shares one SHAKE128 sponge core
// among N requesters.
//
// For each job the arbiter:
//   1. grants one requester and captures its seed, domain and length;
//   2. resets the sponge core for one cycle, because the core only leaves its
//      done state through reset;
//   3. pulses the core's enable for one cycle;
//   4. waits for done, or gives up when the watchdog reaches TIMEOUT;
//   5. holds the masked result until the owning requester takes it.
//
// Handshake: resp_valid rises the cycle after the arbiter enters DELIVER.
// While resp_valid is high, resp_id, resp_err and resp_data are stable. A
// transfer happens on a cycle where resp_valid && resp_ready. resp_valid drops
// on the following cycle. No grant is issued on the transfer cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req                 per-requester request level (must drop by grant+1)
//   req_in/_domain/_len per-requester seed, domain and bit length (packed slices)
//   grant               one-hot, one-cycle pulse; fields are captured on this cycle
//   resp_valid/_id/_err/_data, resp_ready   result handshake
//   busy                high in every state other than IDLE
//   sp_rst, sp_enable   registered reset and start to the sponge core
//   sp_in/_domain/_len  captured job fields; held from grant to the next grant
//   sp_done, sp_out     sponge completion (sticky) and output string
//   dbg_state           current FSM state, for observation
module sponge_arbiter #(
  parameter int N       = 4,
  parameter int MAX_LEN = 5376,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*256-1:0]   req_in,
  input  logic [N*4-1:0]     req_domain,
  input  logic [N*14-1:0]    req_len,
  output logic [N-1:0]       grant,
  output logic               resp_valid,
  output logic [2:0]         resp_id,
  output logic               resp_err,
  output logic [MAX_LEN-1:0] resp_data,
  input  logic               resp_ready,
  output logic               busy,
  output logic               sp_rst,
  output logic               sp_enable,
  output logic [255:0]       sp_in,
  output logic [3:0]         sp_domain,
  output logic [13:0]        sp_len,
  input  logic               sp_done,
  input  logic [MAX_LEN-1:0] sp_out,
  output logic [2:0]         dbg_state
);

  localparam int          CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [13:0] MAX_LEN14 = 14'(MAX_LEN);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPRST   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_DELIVER = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q;
  logic [CW-1:0]      wd_q;
  logic               resp_valid_q, resp_err_q, sp_rst_q, sp_enable_q;
  logic [2:0]         resp_id_q;
  logic [MAX_LEN-1:0] resp_data_q;
  logic [255:0]       sp_in_q;
  logic [3:0]         sp_domain_q;
  logic [13:0]        sp_len_q;

  // Round-robin pick. The first loop finds the lowest set request overall,
  // which is the wrap-around choice. The second loop overrides it with the
  // lowest set request at or above the pointer, when there is one.
  logic       sel_found;
  logic [2:0] sel_idx;
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(k);
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k] && (k >= int'(ptr_q))) sel_idx = 3'(k);
    end
  end

  // Field mux for the selected requester, and the one-hot grant vector.
  logic [N-1:0] grant_oh;
  logic [255:0] sel_in;
  logic [3:0]   sel_dom;
  logic [13:0]  sel_len, sel_len_c;
  always_comb begin
    grant_oh = '0;
    sel_in   = '0;
    sel_dom  = '0;
    sel_len  = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_idx == 3'(k)) begin
        grant_oh[k] = sel_found;
        sel_in      = req_in[k*256 +: 256];
        sel_dom     = req_domain[k*4 +: 4];
        sel_len     = req_len[k*14 +: 14];
      end
    end
    sel_len_c = (sel_len > MAX_LEN14) ? MAX_LEN14 : sel_len;
  end

  logic take;
  assign take = (state_q == S_IDLE) && sel_found;

  // Keeps sp_out bits below sp_len. sp_len is never 0 in WAIT, so the shift
  // amount stays below MAX_LEN.
  logic [13:0]        shamt;
  logic [MAX_LEN-1:0] len_mask;
  assign shamt    = MAX_LEN14 - sp_len_q;
  assign len_mask = {MAX_LEN{1'b1}} >> shamt;

  // The first WAIT cycle has wd_q == 0. A done seen then may be stale, so
  // it is ignored.
  logic wait_done, wait_to;
  assign wait_done = sp_done && (wd_q != '0);
  assign wait_to   = (wd_q == TIMEOUT_C);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (sel_found) state_d = (sel_len == 14'd0) ? S_DELIVER : S_SPRST;
      S_SPRST:   state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT:    if (wait_done || wait_to) state_d = S_DELIVER;
      S_DELIVER: if (resp_valid_q && resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      wd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      sp_rst_q     <= 1'b1;
      sp_enable_q  <= 1'b0;
      sp_in_q      <= '0;
      sp_domain_q  <= '0;
      sp_len_q     <= '0;
    end else begin
      state_q      <= state_d;
      sp_rst_q     <= (state_d == S_SPRST);
      sp_enable_q  <= (state_d == S_LAUNCH);
      resp_valid_q <= (state_q == S_DELIVER) && (state_d == S_DELIVER);

      if (take) begin
        ptr_q       <= 3'((int'(sel_idx) + 1) % N);
        resp_id_q   <= sel_idx;
        sp_in_q     <= sel_in;
        sp_domain_q <= sel_dom;
        sp_len_q    <= sel_len_c;
        if (sel_len == 14'd0) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b0;
        end
      end

      if (state_q == S_LAUNCH) wd_q <= '0;
      else if (state_q == S_WAIT) wd_q <= wd_q + 1'b1;

      if ((state_q == S_WAIT) && (state_d == S_DELIVER)) begin
        if (wait_done) begin
          resp_data_q <= sp_out & len_mask;
          resp_err_q  <= 1'b0;
        end else begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end
    end
  end

  assign grant      = (!rst && state_q == S_IDLE) ? grant_oh : '0;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != S_IDLE);
  assign sp_rst     = sp_rst_q;
  assign sp_enable  = sp_enable_q;
  assign sp_in      = sp_in_q;
  assign sp_domain  = sp_domain_q;
  assign sp_len     = sp_len_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sponge_arbiter.sv
// Testbench for sponge_arbiter. A behavioural sponge produces a deterministic
// output from (seed, domain) after a chosen latency, or never finishes. A
// round-robin reference model predicts the winner and the masked result of
// each job.
module tb_sponge_arbiter;
  localparam int N       = 4;
  localparam int MAX_LEN = 5376;
  localparam int TIMEOUT = 40;
  localparam int CHUNKS  = MAX_LEN / 256;

  logic               clk, rst;
  logic [N-1:0]       req, grant;
  logic [N*256-1:0]   req_in;
  logic [N*4-1:0]     req_domain;
  logic [N*14-1:0]    req_len;
  logic               resp_valid, resp_err, resp_ready, busy;
  logic [2:0]         resp_id, dbg_state;
  logic [MAX_LEN-1:0] resp_data, sp_out;
  logic               sp_rst, sp_enable, sp_done;
  logic [255:0]       sp_in;
  logic [3:0]         sp_domain;
  logic [13:0]        sp_len;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  int           model_ptr;
  logic [N-1:0] keep;
  logic [255:0] seeds[N];
  logic [3:0]   doms[N];
  logic [13:0]  lens[N];
  logic [MAX_LEN-1:0] exp_q[$];
  logic [2:0]         exp_id_q[$];
  logic               exp_err_q[$];

  // sponge model controls
  bit sp_hang;
  int sp_lat;
  bit sp_run;
  int sp_cnt;

  sponge_arbiter #(.N(N), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_in(req_in), .req_domain(req_domain),
    .req_len(req_len), .grant(grant), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_err(resp_err), .resp_data(resp_data), .resp_ready(resp_ready),
    .busy(busy), .sp_rst(sp_rst), .sp_enable(sp_enable), .sp_in(sp_in),
    .sp_domain(sp_domain), .sp_len(sp_len), .sp_done(sp_done), .sp_out(sp_out),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [MAX_LEN-1:0] gen(input logic [255:0] s, input logic [3:0] d);
    logic [MAX_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < CHUNKS; i++)
      r[i*256 +: 256] = s ^ {64{d}} ^ {8{32'((i + 1) * 32'h9E3779B9)}};
    return r;
  endfunction

  function automatic logic [MAX_LEN-1:0] low_mask(input int len);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < len);
    return m;
  endfunction

  // behavioural sponge: done rises sp_lat+2 cycles after the enable cycle
  always @(posedge clk) begin
    if (sp_rst) begin
      sp_done <= 1'b0;
      sp_run  <= 1'b0;
    end else if (sp_enable) begin
      sp_run <= 1'b1;
      sp_cnt <= sp_lat;
    end else if (sp_run && !sp_hang) begin
      if (sp_cnt == 0) begin
        sp_done <= 1'b1;
        sp_out  <= gen(sp_in, sp_domain);
        sp_run  <= 1'b0;
      end else begin
        sp_cnt <= sp_cnt - 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive_fields();
    for (int k = 0; k < N; k++) begin
      req_in[k*256 +: 256] = seeds[k];
      req_domain[k*4 +: 4] = doms[k];
      req_len[k*14 +: 14]  = lens[k];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [MAX_LEN-1:0] obs,
                          input logic [MAX_LEN-1:0] exp);
    int first;
    first = -1;
    for (int i = MAX_LEN - 1; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: first bad bit %0d, observed[63:0] %h expected[63:0] %h",
             tag, first, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_resp_id"}, 64'(resp_id), 64'(0));
    chk({tag, "_resp_err"}, 64'(resp_err), 64'(0));
    chk_wide({tag, "_resp_data"}, resp_data, '0);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_sp_rst"}, 64'(sp_rst), 64'(1));
    chk({tag, "_sp_enable"}, 64'(sp_enable), 64'(0));
    chk_wide({tag, "_sp_in"}, MAX_LEN'(sp_in), '0);
    chk({tag, "_sp_domain"}, 64'(sp_domain), 64'(0));
    chk({tag, "_sp_len"}, 64'(sp_len), 64'(0));
  endtask

  function automatic int model_pick();
    for (int o = 0; o < N; o++) if (req[(model_ptr + o) % N]) return (model_ptr + o) % N;
    return 0;
  endfunction

  // One complete job, called in an IDLE cycle with req already driven.
  task automatic job(input int ready_wait, input bit clear_after, output int got);
    int k, eff, g_c, rst_n, en_n, rst_c, en_c, done_c, gcnt, lat_exp;
    bit seen, drop;
    logic [N-1:0] exp_g;
    logic [MAX_LEN-1:0] snap, e_data;
    logic [2:0] e_id;
    logic e_err;

    k   = model_pick();
    eff = (int'(lens[k]) > MAX_LEN) ? MAX_LEN : int'(lens[k]);
    exp_id_q.push_back(3'(k));
    if (eff == 0) begin
      exp_q.push_back('0);
      exp_err_q.push_back(1'b0);
    end else if (sp_hang) begin
      exp_q.push_back('0);
      exp_err_q.push_back(1'b1);
    end else begin
      exp_q.push_back(gen(seeds[k], doms[k]) & low_mask(eff));
      exp_err_q.push_back(1'b0);
    end

    #1;
    got = -1;
    for (int b = 0; b < N; b++) if (grant[b]) got = b;
    exp_g    = '0;
    exp_g[k] = 1'b1;
    chk("grant", 64'(grant), 64'(exp_g));
    g_c  = cyc;
    drop = !keep[k];
    model_ptr = (k + 1) % N;
    gcnt = (grant != '0) ? 1 : 0;
    rst_n = 0; en_n = 0; rst_c = 0; en_c = 0; done_c = -1; seen = 0;

    for (int i = 0; i < TIMEOUT + 40; i++) begin
      tick();
      if (drop) begin
        req[k] = 1'b0;
        drop   = 0;
      end
      #1;
      if (grant != '0) gcnt++;
      if (sp_rst === 1'b1) begin rst_n++; rst_c = cyc; end
      if (sp_enable === 1'b1) begin
        en_n++;
        en_c = cyc;
        chk_wide("sp_in", MAX_LEN'(sp_in), MAX_LEN'(seeds[k]));
        chk("sp_domain", 64'(sp_domain), 64'(doms[k]));
        chk("sp_len", 64'(sp_len), 64'(eff));
      end
      if (sp_done === 1'b1 && done_c < 0 && en_n > 0) done_c = cyc;
      if (resp_valid === 1'b1) begin seen = 1; break; end
    end

    e_data = exp_q.pop_front();
    e_id   = exp_id_q.pop_front();
    e_err  = exp_err_q.pop_front();
    chk("resp_seen", 64'(seen), 64'(1));
    chk("resp_id", 64'(resp_id), 64'(e_id));
    chk("resp_err", 64'(resp_err), 64'(e_err));
    chk_wide("resp_data", resp_data, e_data);

    if (eff == 0)     lat_exp = 2;
    else if (sp_hang) lat_exp = TIMEOUT + 5;
    else              lat_exp = 4 + (done_c - en_c);
    chk("latency", 64'(cyc - g_c), 64'(lat_exp));
    chk("sp_rst_pulses", 64'(rst_n), 64'((eff == 0) ? 0 : 1));
    chk("sp_enable_pulses", 64'(en_n), 64'((eff == 0) ? 0 : 1));
    if (eff != 0) chk("rst_before_enable", 64'(en_c - rst_c), 64'(1));

    snap = resp_data;
    repeat (ready_wait) begin
      tick();
      #1;
      if (grant != '0) gcnt++;
    end
    chk("hold_valid", 64'(resp_valid), 64'(1));
    chk("hold_id", 64'(resp_id), 64'(e_id));
    chk_wide("hold_data", resp_data, snap);

    resp_ready = 1'b1;
    #1;
    if (grant != '0) gcnt++;
    tick();
    resp_ready = 1'b0;
    if (clear_after) req = '0;
    #1;
    chk("valid_clear", 64'(resp_valid), 64'(0));
    chk("busy_clear", 64'(busy), 64'(0));
    chk("one_grant", 64'(gcnt), 64'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int got, j;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1; resp_ready = 1'b0; req = '1;
    req_in = '0; req_domain = '0; req_len = '0;
    sp_hang = 0; sp_lat = 1; keep = '0; model_ptr = 0;
    for (int k = 0; k < N; k++) begin seeds[k] = '0; doms[k] = '0; lens[k] = '0; end

    repeat (3) tick();
    #1;
    chk_reset_vals("reset");
    req = '0;
    rst = 1'b0;
    tick();

    // all requesters continuously asserted, full length
    for (int k = 0; k < N; k++) begin
      seeds[k] = {8{$urandom()}};
      doms[k]  = 4'(k + 3);
      lens[k]  = 14'(MAX_LEN);
    end
    drive_fields();
    keep = '1;
    req  = '1;
    for (int i = 0; i < 5; i++) begin
      job(0, i == 4, got);
      chk("rr_order", 64'(got), 64'(order[i]));
    end
    keep = '0;

    // single requester 0
    seeds[0] = 256'h1; doms[0] = 4'hF; lens[0] = 14'd1024;
    drive_fields(); sp_lat = 3; req = 4'b0001;
    job(0, 0, got);
    chk("single_id", 64'(got), 64'(0));

    // zero length on requester 2: sponge untouched
    lens[2] = 14'd0; drive_fields(); req = 4'b0100;
    job(0, 0, got);
    chk("len0_id", 64'(got), 64'(2));

    // over-long length is clamped
    lens[1] = 14'd9000; drive_fields(); req = 4'b0010;
    job(1, 0, got);

    // sponge never finishes, then a normal job
    sp_hang = 1; lens[3] = 14'd100; drive_fields(); req = 4'b1000;
    job(0, 0, got);
    sp_hang = 0; lens[0] = 14'd777; drive_fields(); req = 4'b0001;
    job(0, 0, got);

    // ready held low for 10 cycles
    lens[1] = 14'd300; seeds[1] = {8{$urandom()}}; drive_fields(); req = 4'b0010;
    job(10, 0, got);

    // reset in the middle of WAIT
    sp_hang = 1; seeds[1] = {8{$urandom()}}; drive_fields(); req = 4'b0010;
    #1;
    chk("mid_grant", 64'(grant), 64'(4'b0010));
    tick();
    req = '0;
    repeat (5) tick();
    #1;
    chk("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    tick(); tick();
    #1;
    chk_reset_vals("midreset");
    rst = 1'b0; sp_hang = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      chk("no_resp_after_reset", 64'(resp_valid), 64'(0));
    end
    model_ptr = 0;

    // pointer restarts at 0 after reset
    lens[1] = 14'd64; lens[3] = 14'd200; drive_fields(); req = 4'b1010;
    job(0, 0, got);
    chk("ptr_after_reset", 64'(got), 64'(1));
    job(0, 0, got);
    chk("ptr_next", 64'(got), 64'(3));

    // randomized jobs
    j = 0;
    while (j < 14 || req != '0) begin
      if (req == '0) begin
        for (int k = 0; k < N; k++) begin
          seeds[k] = {8{$urandom()}};
          doms[k]  = 4'($urandom_range(0, 15));
          lens[k]  = ($urandom_range(0, 9) == 0) ? 14'd0 : 14'($urandom_range(1, 9000));
        end
        drive_fields();
        req = N'($urandom_range(1, (1 << N) - 1));
      end
      sp_lat = $urandom_range(0, 6);
      job($urandom_range(0, 3), 0, got);
      j++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sponge_arbiter.md
Name: sponge_arbiter

Overview:
- Round-robin scheduler that shares one SHAKE128 sponge instance (sponge_const) among N requesters, e.g. matrix-A generation, noise sampling and hash units.
- Per job it captures the requester's seed, domain and length, then resets and launches the sponge. It waits for done, holds the result until the requester accepts it, and enforces a watchdog timeout.
- It sits between the Kyber encapsulation units and the single sponge core. Its sp_* ports wire directly to that core.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_LEN, 5376, maximum squeeze length in bits (4 x rate 1344).
- TIMEOUT, 4095, maximum cycles in WAIT before the job is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  N  per-requester request level
- req_in  in  N*256  per-requester seed/coins; slice k is [k*256 +: 256]
- req_domain  in  N*4  per-requester domain separator
- req_len  in  N*14  per-requester output length in bits
- grant  out  N  one-hot, one-cycle pulse; fields are captured on this cycle
- resp_valid  out  1  result held for resp_id
- resp_id  out  3  index of the requester that owns the result
- resp_err  out  1  qualifies resp_valid: the job timed out
- resp_data  out  MAX_LEN  squeezed bits; bits at or above the job length are zero
- resp_ready  in  1  the owning requester accepts the result
- busy  out  1  high in any state other than IDLE
- sp_rst  out  1  reset to the sponge core (registered)
- sp_enable  out  1  start pulse to the sponge core
- sp_in  out  256  captured seed
- sp_domain  out  4  captured domain
- sp_len  out  14  captured, clamped length
- sp_done  in  1  sponge done (sticky until the sponge is reset)
- sp_out  in  MAX_LEN  sponge output_string

Behaviour:
- Reset values: grant=0, resp_valid=0, resp_id=0, resp_err=0, resp_data=0, busy=0, sp_rst=1, sp_enable=0, sp_in=0, sp_domain=0, sp_len=0. Round-robin pointer=0. State=IDLE.
- rst asserted mid-job aborts the job with no response. The sponge is also reset, because sp_rst=1 while rst is high.
- The sponge only leaves its done state via reset, so every job begins with a 1-cycle sp_rst pulse.
- States: IDLE, SPRST, LAUNCH, WAIT, DELIVER.
- IDLE, no req: stay in IDLE.
- IDLE, any req:
  - Select the first set req at or after the pointer, wrapping modulo N.
  - Pulse grant[k] for that cycle and capture req_in, req_domain and len_k.
  - Clamp: if len_k > MAX_LEN, sp_len=MAX_LEN.
  - Set pointer=(k+1) mod N and resp_id=k.
  - If len_k==0: go straight to DELIVER with resp_data=0 and resp_err=0; the core is not touched.
  - Otherwise go to SPRST.
- Requesters must drop req by the cycle after grant. A req still high after that is treated as a new request.
- SPRST: sp_rst=1 for exactly 1 cycle, then LAUNCH.
- LAUNCH: sp_rst=0, sp_enable=1 for exactly 1 cycle. Clear the watchdog counter, then go to WAIT.
- WAIT:
  - sp_done is ignored on the first WAIT cycle, to guard against a stale done.
  - sp_done=1: register resp_data=sp_out with bits at or above sp_len forced to 0, set resp_err=0, go to DELIVER.
  - Counter reaches TIMEOUT: resp_data=0, resp_err=1, go to DELIVER.
- DELIVER:
  - resp_valid=1 is registered, so it rises the cycle after entry.
  - resp_data, resp_id and resp_err are stable while resp_valid=1.
  - resp_valid & resp_ready: clear resp_valid next cycle and return to IDLE. No grant is issued in that same cycle, so there is 1 idle cycle minimum between jobs.
  - New req in DELIVER or any busy state: wait, no grant.
- Latency: grant to resp_valid = 3 + (sponge cycles to done) + 1 cycles.
- Simultaneous req: round-robin order from the pointer. No requester starves; with all N asserting continuously each is served once per N jobs.
- sp_in, sp_domain and sp_len hold their captured values from grant until the next grant.

Test Plan:
- Single requester 0: req_in=0x00..01, domain=0xF, len=1024 -> grant[0] pulses 1 cycle; one sp_rst pulse then one sp_enable pulse; resp_valid with resp_id=0; resp_data[1023:0] equals the SHAKE128 golden value; bits above 1023 are zero; resp_err=0.
- All 4 req high continuously, each with a distinct seed, len=5376 -> grants occur in order 0,1,2,3,0; each resp_data matches its own seed's golden output; exactly one grant per job.
- len=0 on requester 2 -> resp_valid with resp_id=2 and resp_data=0; sp_rst and sp_enable never pulse.
- len=9000 -> sp_len=5376 and the full 5376-bit output is delivered.
- Sponge model that never asserts done -> after TIMEOUT+1 WAIT cycles resp_valid=1 with resp_err=1 and resp_data=0; the next job completes normally.
- Reset mid-WAIT and resp_ready held low for 10 cycles in DELIVER -> rst returns all outputs to reset values with no response; resp_data is stable while ready is low; resp_valid clears the cycle after ready goes high.
